// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci/Lucas sequence engine.
package fib_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_t;

  localparam logic MODE_FIB   = 1'b0;
  localparam logic MODE_LUCAS = 1'b1;

  localparam int unsigned FIB_SEED0   = 0;
  localparam int unsigned FIB_SEED1   = 1;
  localparam int unsigned LUCAS_SEED0 = 2;
  localparam int unsigned LUCAS_SEED1 = 1;

endpackage

// File: rtl/fib_seq_engine_if.sv
// Start/status bus between the requester and the sequence engine.
interface fib_seq_engine_if #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned N_WIDTH = 8
) ();

  logic               stb;
  logic [N_WIDTH-1:0] n;
  logic               mode;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic               overflow;

  modport master (
    output stb, n, mode,
    input  busy, done, result, overflow
  );

  modport slave (
    input  stb, n, mode,
    output busy, done, result, overflow
  );

endinterface

// File: rtl/fib_sat_adder.sv
// Term adder for the sequence engine. With FIB_SATURATE_EN defined the sum
// clamps to all-ones on carry; otherwise it wraps modulo 2^WIDTH.
module fib_sat_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum_c,
  output logic             carry_c
);

  logic [WIDTH:0] full_sum;

  // Widened add, then wrap or clamp depending on build.
  always_comb begin
    full_sum = {1'b0, a} + {1'b0, b};
    carry_c  = full_sum[WIDTH];
`ifdef FIB_SATURATE_EN
    sum_c    = full_sum[WIDTH] ? '1 : full_sum[WIDTH-1:0];
`else
    sum_c    = full_sum[WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/fib_seq_engine.sv
// Iterative Fibonacci/Lucas engine: stb starts a run, busy covers it,
// done pulses when result/overflow update. Saturating adder selected by
// the FIB_SATURATE_EN macro.
module fib_seq_engine
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned N_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  fib_seq_engine_if.slave  bus
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               ovf_a_q, ovf_a_d, ovf_b_q, ovf_b_d;
  logic [N_WIDTH-1:0] cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               overflow_q, overflow_d;

  logic [WIDTH-1:0]   sum_c;
  logic               carry_c;

  fib_sat_adder #(.WIDTH(WIDTH)) u_adder (
    .a       (a_q),
    .b       (b_q),
    .sum_c   (sum_c),
    .carry_c (carry_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, datapath and output values.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    ovf_a_d    = ovf_a_q;
    ovf_b_d    = ovf_b_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.stb) begin
          a_d        = (bus.mode == MODE_LUCAS) ? WIDTH'(LUCAS_SEED0) : WIDTH'(FIB_SEED0);
          b_d        = (bus.mode == MODE_LUCAS) ? WIDTH'(LUCAS_SEED1) : WIDTH'(FIB_SEED1);
          cnt_d      = bus.n;
          ovf_a_d    = 1'b0;
          ovf_b_d    = 1'b0;
          overflow_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_CALC;
        end
      end
      ST_CALC: begin
        if (cnt_q != '0) begin
          // b runs one term ahead, so an overflow only surfaces once it shifts into a.
          a_d     = b_q;
          b_d     = sum_c;
          ovf_a_d = ovf_b_q;
          ovf_b_d = ovf_a_q | ovf_b_q | carry_c;
          cnt_d   = cnt_q - N_WIDTH'(1);
        end else begin
          result_d   = a_q;
          overflow_d = ovf_a_q;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      ovf_a_q    <= 1'b0;
      ovf_b_q    <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      ovf_a_q    <= ovf_a_d;
      ovf_b_q    <= ovf_b_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_fib_seq_engine.sv
// Scoreboard bench for fib_seq_engine (WIDTH=8): the driver queues expected
// completions, a monitor checks each done pulse against the queue.
module tb_fib_seq_engine;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned N_WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] result;
    logic             overflow;
    int               busy_len;
    string            name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fib_seq_engine_if #(.WIDTH(WIDTH), .N_WIDTH(N_WIDTH)) bus ();

  fib_seq_engine #(.WIDTH(WIDTH), .N_WIDTH(N_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   busy_run = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: compare each done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else if (bus.done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_result"}, int'(bus.result), int'(e.result));
        check({e.name, "_overflow"}, int'(bus.overflow), int'(e.overflow));
        check({e.name, "_busy_len"}, busy_run, e.busy_len);
        check({e.name, "_busy_low_at_done"}, int'(bus.busy), 0);
      end
      busy_run = 0;
    end else if (bus.busy) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
  end

  // Present one start request for a single cycle and queue its expected completion.
  task automatic start(input int n, input logic mode, input int exp_res,
                       input logic exp_ovf, input string name);
    exp_t e;
    e.result   = WIDTH'(exp_res);
    e.overflow = exp_ovf;
    e.busy_len = n + 1;
    e.name     = name;
    exp_q.push_back(e);
    bus.stb  = 1'b1;
    bus.n    = N_WIDTH'(n);
    bus.mode = mode;
    @(negedge clk);
    bus.stb  = 1'b0;
  endtask

  // Wait until the scoreboard drains, bounded.
  task automatic wait_drain(input string name);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() != 0) begin
      check({name, "_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  int fib_tab[11] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55};

  initial begin
    bus.stb  = 1'b0;
    bus.n    = '0;
    bus.mode = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_result", int'(bus.result), 0);
    check("reset_overflow", int'(bus.overflow), 0);
    rst = 1'b0;
    @(negedge clk);

    // Fibonacci terms 0..10.
    for (int i = 0; i <= 10; i++) begin
      start(i, 1'b0, fib_tab[i], 1'b0, $sformatf("fib_n%0d", i));
      wait_drain("fib");
    end

    // Lucas mode.
    start(5, 1'b1, 11, 1'b0, "lucas_n5");
    wait_drain("lucas5");
    start(0, 1'b1, 2, 1'b0, "lucas_n0");
    wait_drain("lucas0");

    // Overflow boundary: b overflows at n=13, a at n=14.
    start(13, 1'b0, 233, 1'b0, "fib_n13");
    wait_drain("fib13");
`ifdef FIB_SATURATE_EN
    start(14, 1'b0, 255, 1'b1, "fib_n14_sat");
`else
    start(14, 1'b0, 121, 1'b1, "fib_n14_wrap");
`endif
    wait_drain("fib14");

    // stb while busy is ignored.
    start(10, 1'b0, 55, 1'b0, "busy_ignore");
    repeat (3) @(negedge clk);
    bus.stb = 1'b1;
    bus.n   = N_WIDTH'(3);
    @(negedge clk);
    bus.stb = 1'b0;
    wait_drain("busy_ignore");
    repeat (5) @(negedge clk);

    // Reset mid-calculation aborts without done.
    start(20, 1'b0, 0, 1'b0, "aborted");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_done", int'(bus.done), 0);
    check("midrst_result", int'(bus.result), 0);
    check("midrst_overflow", int'(bus.overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    start(6, 1'b0, 8, 1'b0, "after_rst_n6");
    wait_drain("after_rst");

    // Back-to-back: new stb in the done cycle is accepted.
    start(4, 1'b0, 3, 1'b0, "b2b_first");
    begin
      int cyc = 0;
      while (!bus.done && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      check("b2b_done_seen", int'(bus.done), 1);
    end
    start(7, 1'b0, 13, 1'b0, "b2b_second");
    wait_drain("b2b");

    repeat (5) @(negedge clk);
    check("total_done_pulses", done_cnt, 11 + 2 + 2 + 1 + 1 + 2);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
